// File: rtl/sqrt_pkg.sv
// Shared types for the sequential integer square root: FSM state encoding
// and the radicand-to-root width relation.
package sqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic int root_width(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/sqrt_sub_row.sv
// One restoring square-root row: shift two radicand bits into the partial
// remainder, trial-subtract (root << 2) | 1 with a ripple-borrow chain, select.
module sqrt_sub_row
  import sqrt_pkg::*;
#(
  parameter int ROOT_W = 16
) (
  input  logic [ROOT_W-1:0] rem_i,
  input  logic [1:0]        bits_i,
  input  logic [ROOT_W-2:0] root_i,
  output logic [ROOT_W:0]   rem_o,
  output logic              root_bit_o
);

  localparam int TW = ROOT_W + 2;

  // Partial remainder <= 2*partial root < 2^ROOT_W before the last step, so
  // ROOT_W+2 bits always hold the shifted remainder and the trial divisor.
  logic [TW-1:0]   shifted;
  logic [TW-1:0]   divisor;
  logic [ROOT_W:0] diff;
  logic            borrow;

  assign shifted = {rem_i, bits_i};
  assign divisor = {1'b0, root_i, 2'b01};

  always_comb begin : ripple
    logic bw;
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned (which would infer a latch); blocking '=' is required
    // here because each cell reads the borrow the previous cell just wrote.
    bw   = 1'b0;
    diff = '0;
    for (int i = 0; i <= ROOT_W; i++) begin
      diff[i] = shifted[i] ^ divisor[i] ^ bw;
      bw      = (~shifted[i] & divisor[i]) | (~(shifted[i] ^ divisor[i]) & bw);
    end
    borrow = (~shifted[TW-1] & divisor[TW-1]) |
             (~(shifted[TW-1] ^ divisor[TW-1]) & bw);
  end

  assign root_bit_o = ~borrow;
  assign rem_o      = borrow ? shifted[ROOT_W:0] : diff;

endmodule

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: one root bit per clock through a
// single shared sqrt_sub_row, valid/ready on both sides, zero-bubble reload.
module isqrt_seq
  import sqrt_pkg::*;
#(
  parameter  int WIDTH  = 32,
  localparam int ROOT_W = root_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  radicand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROOT_W-1:0] root,
  output logic [ROOT_W:0]   remainder,
  output logic              busy
);

  localparam int PR_W  = ROOT_W - 1;
  localparam int CNT_W = $clog2(ROOT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  rad_q, rad_d;
  logic [PR_W-1:0]   proot_q, proot_d;
  logic [ROOT_W-1:0] prem_q, prem_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [ROOT_W:0]   rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROOT_W:0]   row_rem;
  logic              row_bit;
  logic              load;

  sqrt_sub_row #(.ROOT_W(ROOT_W)) u_row (
    .rem_i      (prem_q),
    .bits_i     (rad_q[WIDTH-1 -: 2]),
    .root_i     (proot_q),
    .rem_o      (row_rem),
    .root_bit_o (row_bit)
  );

  always_comb begin
    state_d  = state_q;
    rad_d    = rad_q;
    proot_d  = proot_q;
    prem_d   = prem_q;
    root_d   = root_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      ST_COMPUTE: begin
        rad_d   = {rad_q[WIDTH-3:0], 2'b00};
        proot_d = PR_W'({proot_q, row_bit});
        prem_d  = row_rem[ROOT_W-1:0];
        if (cnt_q == '0) begin
          // Final step: the result registers hold still until the next one.
          state_d = ST_DONE;
          root_d  = {proot_q, row_bit};
          rem_d   = row_rem;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      state_d = ST_COMPUTE;
      rad_d   = radicand;
      proot_d = '0;
      prem_d  = '0;
      cnt_d   = CNT_LAST;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rad_q   <= '0;
      proot_q <= '0;
      prem_q  <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      proot_q <= proot_d;
      prem_q  <= prem_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_COMPUTE);
  assign root      = root_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq at WIDTH=8 and WIDTH=32 against an
// arithmetic floor-sqrt reference model.
module tb_isqrt_seq;

  localparam int R8  = 4;
  localparam int R32 = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [7:0]  a_rad;
  logic [3:0]  a_root;
  logic [4:0]  a_rem;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_rad;
  logic [15:0] b_root;
  logic [16:0] b_rem;

  isqrt_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .radicand(a_rad),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .root(a_root), .remainder(a_rem), .busy(a_busy)
  );

  isqrt_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .radicand(b_rad),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .root(b_root), .remainder(b_rem), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;
  longint unsigned stim_q[$];
  longint unsigned res_root[$];
  longint unsigned res_rem[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Largest r with r*r <= x, by binary search over the 16-bit root range.
  function automatic longint unsigned ref_isqrt(input longint unsigned x);
    longint unsigned lo = 0;
    longint unsigned hi = 65536;
    longint unsigned mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else                hi = mid;
    end
    return lo;
  endfunction

  // Feeds stim_q into one instance and scores every result; rand_hs toggles
  // in_valid/out_ready randomly, otherwise both stay high (zero-bubble mode).
  task automatic stream(input bit big, input bit rand_hs, input int budget);
    longint unsigned exp_q[$];
    int              acc_q[$];
    int              total, rw;
    int              n_res = 0;
    int              cyc = 0;
    int              last_res = -1;
    bit              seen = 1'b0;
    bit              ovr, ivr, ov, ir;
    longint unsigned x, er, r_root, r_rem;
    rw    = big ? R32 : R8;
    total = stim_q.size();
    res_root.delete();
    res_rem.delete();
    while (n_res < total && cyc < budget) begin
      @(negedge clk);
      cyc++;
      ovr = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
      ivr = (stim_q.size() != 0) && (rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1);
      x   = ivr ? stim_q[0] : 64'($urandom);
      if (big) begin
        b_out_ready = ovr; b_in_valid = ivr; b_rad = 32'(x);
      end else begin
        a_out_ready = ovr; a_in_valid = ivr; a_rad = 8'(x);
      end
      #1;
      ov     = big ? b_out_valid : a_out_valid;
      ir     = big ? b_in_ready : a_in_ready;
      r_root = big ? 64'(b_root) : 64'(a_root);
      r_rem  = big ? 64'(b_rem) : 64'(a_rem);
      if (ov && !seen) begin
        seen = 1'b1;
        check("outstanding", exp_q.size(), 1);
        if (acc_q.size() != 0) check("latency", cyc - acc_q[0], rw + 1);
      end
      if (ov && ovr && exp_q.size() != 0) begin
        x  = exp_q.pop_front();
        void'(acc_q.pop_front());
        er = ref_isqrt(x);
        check("root", r_root, er);
        check("rem", r_rem, x - er * er);
        check("identity", r_root * r_root + r_rem, x);
        check("rem_bound", r_rem <= 2 * r_root, 1);
        if (!rand_hs && last_res >= 0) check("spacing", cyc - last_res, rw + 1);
        last_res = cyc;
        res_root.push_back(r_root);
        res_rem.push_back(r_rem);
        seen = 1'b0;
        n_res++;
      end
      if (ivr && ir) begin
        exp_q.push_back(stim_q.pop_front());
        acc_q.push_back(cyc);
      end
    end
    check("stream_done", n_res, total);
    stim_q.delete();
    @(negedge clk);
    if (big) begin
      b_in_valid = 1'b0; b_out_ready = 1'b0;
    end else begin
      a_in_valid = 1'b0; a_out_ready = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_rad = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_rad = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_root", a_root, 0);
    check("rst_a_rem", a_rem, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_busy", b_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", a_in_ready, 1);

    // Radicand 0 at WIDTH=8
    stim_q = '{64'd0};
    stream(1'b0, 1'b0, 100);
    check("zero_count", res_root.size(), 1);
    if (res_root.size() == 1) begin
      check("zero_root", res_root[0], 0);
      check("zero_rem", res_rem[0], 0);
    end

    // Back-to-back 144, 143, 255 with out_ready tied high
    stim_q = '{64'd144, 64'd143, 64'd255};
    stream(1'b0, 1'b0, 100);
    check("b2b_count", res_root.size(), 3);
    if (res_root.size() == 3) begin
      check("b2b_144_root", res_root[0], 12);
      check("b2b_144_rem", res_rem[0], 0);
      check("b2b_143_root", res_root[1], 11);
      check("b2b_143_rem", res_rem[1], 22);
      check("b2b_255_root", res_root[2], 15);
      check("b2b_255_rem", res_rem[2], 30);
    end

    // Full-scale radicand at WIDTH=32
    stim_q = '{64'hFFFF_FFFF};
    stream(1'b1, 1'b0, 100);
    check("max32_count", res_root.size(), 1);
    if (res_root.size() == 1) begin
      check("max32_root", res_root[0], 65535);
      check("max32_rem", res_rem[0], 131070);
    end

    // Backpressure: result held 5 cycles while a new operand is offered
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_rad = 8'd200;
    @(negedge clk);
    a_in_valid = 1'b0; a_rad = 8'($urandom);
    n = 0;
    while (!a_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", n, R8);
    a_in_valid = 1'b1; a_rad = 8'd99;
    repeat (5) begin
      #1;
      check("bp_valid", a_out_valid, 1);
      check("bp_root", a_root, 14);
      check("bp_rem", a_rem, 4);
      check("bp_in_ready", a_in_ready, 0);
      check("bp_busy", a_busy, 0);
      @(negedge clk);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    #1;
    check("bp_release_valid", a_out_valid, 0);
    check("bp_release_busy", a_busy, 0);
    check("bp_release_in_ready", a_in_ready, 1);

    // Reset pulsed at iteration 2 of 4
    @(negedge clk);
    a_in_valid = 1'b1; a_rad = 8'd200;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("mid_busy_before", a_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_out_valid", a_out_valid, 0);
    check("mid_rst_in_ready", a_in_ready, 1);
    check("mid_rst_root", a_root, 0);
    check("mid_rst_rem", a_rem, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_release_in_ready", a_in_ready, 1);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_out_valid || a_busy) n++;
    end
    check("mid_rst_no_output", n, 0);
    stim_q = '{64'd49};
    stream(1'b0, 1'b0, 100);
    check("after_rst_count", res_root.size(), 1);
    if (res_root.size() == 1) begin
      check("after_rst_root", res_root[0], 7);
      check("after_rst_rem", res_rem[0], 0);
    end

    // Random regression: 10k radicands across both widths and handshake modes
    for (int i = 0; i < 8000; i++) stim_q.push_back(64'($urandom_range(0, 255)));
    stream(1'b0, 1'b0, 50000);
    for (int i = 0; i < 1700; i++) stim_q.push_back(64'($urandom_range(0, 255)));
    stream(1'b0, 1'b1, 1700 * 20);
    stim_q.push_back(64'd1);
    stim_q.push_back(64'hFFFF_FFFE);
    for (int i = 0; i < 300; i++) stim_q.push_back(64'($urandom));
    stream(1'b1, 1'b0, 302 * 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
